// File: rtl/arc4_crack.sv
// arc4_crack: brute-force ARC4 key search over a 24-bit key space against a printable-ASCII oracle.
// Latency: one candidate takes 256 (init) + 768 (ksa) + 1 (len) + 5*L (prga) + 1 (next) cycles.
// Backpressure: en is taken only while rdy=1; kv aborts any running search on the next edge.
//
// Ports:
//   clk        - single clock, rising edge
//   rst_n      - synchronous reset, active HIGH despite the name
//   en/rdy     - start request / idle-and-ready
//   key_start  - first candidate key, captured when en is accepted
//   key        - current candidate; the found key after a successful search
//   key_valid  - last search succeeded (meaningful while rdy=1)
//   ct_addr/ct_rddata - ciphertext ROM port, data valid one cycle after address
//   kv         - external abort (a peer found the key)
//   flagk      - one-cycle pulse on success
//
// Build option: define CRACK_STRIDE2_EN to step candidates by 2 instead of 1, so two
// instances started at even/odd keys split the key space between them.

module arc4_crack (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic        rdy,
    input  logic [23:0] key_start,
    output logic [23:0] key,
    output logic        key_valid,
    output logic [7:0]  ct_addr,
    input  logic [7:0]  ct_rddata,
    input  logic        kv,
    output logic        flagk
);

`ifdef CRACK_STRIDE2_EN
    localparam logic [24:0] KEY_STEP = 25'd2;
`else
    localparam logic [24:0] KEY_STEP = 25'd1;
`endif

    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT,
        S_KSA_RI,
        S_KSA_RJ,
        S_KSA_SW,
        S_PRGA_LEN,
        S_PRGA_RI,
        S_PRGA_RJ,
        S_PRGA_SW,
        S_PRGA_RP,
        S_PRGA_CHK,
        S_NEXT
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  i_q, i_d;
    logic [7:0]  j_q, j_d;
    logic [1:0]  km_q, km_d;      // i mod 3, tracked incrementally during KSA
    logic [7:0]  si_q, si_d;      // S[i] captured before the swap
    logic [7:0]  sj_q, sj_d;      // S[j] captured before the swap
    logic [7:0]  len_q, len_d;
    logic [7:0]  k_q, k_d;        // ciphertext byte index 1..L
    logic [23:0] key_q, key_d;
    logic        key_valid_q, key_valid_d;
    logic        flagk_q, flagk_d;
    logic        rdy_q, rdy_d;
    logic [7:0]  ct_addr_q, ct_addr_d;

    // S array: one synchronous read port, two write ports so a swap lands in one cycle.
    logic [7:0]  s_q [256];
    logic [7:0]  s_rd_q;
    logic [7:0]  s_raddr;
    logic        s_we0, s_we1;
    logic [7:0]  s_wa0, s_wa1, s_wd0, s_wd1;

    logic [7:0]  kbyte;
    logic [7:0]  pt;
    logic [24:0] key_sum;
    logic [7:0]  j_ksa;
    logic [7:0]  j_prga;

    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        j_d         = j_q;
        km_d        = km_q;
        si_d        = si_q;
        sj_d        = sj_q;
        len_d       = len_q;
        k_d         = k_q;
        key_d       = key_q;
        key_valid_d = key_valid_q;
        flagk_d     = 1'b0;
        ct_addr_d   = ct_addr_q;

        s_raddr = i_q;
        s_we0   = 1'b0;
        s_wa0   = i_q;
        s_wd0   = i_q;
        s_we1   = 1'b0;
        s_wa1   = j_q;
        s_wd1   = si_q;

        case (km_q)
            2'd0:    kbyte = key_q[23:16];
            2'd1:    kbyte = key_q[15:8];
            default: kbyte = key_q[7:0];
        endcase

        pt      = ct_rddata ^ s_rd_q;
        key_sum = {1'b0, key_q} + KEY_STEP;
        j_ksa   = j_q + s_rd_q + kbyte;
        j_prga  = j_q + s_rd_q;

        case (state_q)
            S_IDLE: begin
                if (en) begin
                    key_d       = key_start;
                    key_valid_d = 1'b0;
                    i_d         = 8'd0;
                    j_d         = 8'd0;
                    state_d     = S_INIT;
                end
            end

            S_INIT: begin
                s_we0     = 1'b1;
                s_wa0     = i_q;
                s_wd0     = i_q;
                ct_addr_d = 8'd0;          // park on the length byte for PRGA
                i_d       = i_q + 8'd1;
                if (i_q == 8'hFF) begin
                    j_d     = 8'd0;
                    km_d    = 2'd0;
                    state_d = S_KSA_RI;
                end
            end

            S_KSA_RI: begin
                s_raddr = i_q;
                state_d = S_KSA_RJ;
            end

            S_KSA_RJ: begin
                si_d    = s_rd_q;
                j_d     = j_ksa;
                s_raddr = j_ksa;
                state_d = S_KSA_SW;
            end

            S_KSA_SW: begin
                s_we0 = 1'b1;
                s_wa0 = i_q;
                s_wd0 = s_rd_q;
                s_we1 = 1'b1;
                s_wa1 = j_q;
                s_wd1 = si_q;
                i_d   = i_q + 8'd1;
                km_d  = (km_q == 2'd2) ? 2'd0 : km_q + 2'd1;
                if (i_q == 8'hFF) begin
                    j_d     = 8'd0;
                    state_d = S_PRGA_LEN;
                end else begin
                    state_d = S_KSA_RI;
                end
            end

            S_PRGA_LEN: begin
                len_d = ct_rddata;
                k_d   = 8'd1;
                if (ct_rddata == 8'd0) begin
                    key_valid_d = 1'b1;
                    flagk_d     = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    state_d = S_PRGA_RI;
                end
            end

            S_PRGA_RI: begin
                i_d       = i_q + 8'd1;
                s_raddr   = i_q + 8'd1;
                ct_addr_d = k_q;
                state_d   = S_PRGA_RJ;
            end

            S_PRGA_RJ: begin
                si_d    = s_rd_q;
                j_d     = j_prga;
                s_raddr = j_prga;
                state_d = S_PRGA_SW;
            end

            S_PRGA_SW: begin
                sj_d    = s_rd_q;
                s_we0   = 1'b1;
                s_wa0   = i_q;
                s_wd0   = s_rd_q;
                s_we1   = 1'b1;
                s_wa1   = j_q;
                s_wd1   = si_q;
                state_d = S_PRGA_RP;
            end

            // Pad read is issued after the swap has landed, so no bypass is needed.
            S_PRGA_RP: begin
                s_raddr = si_q + sj_q;
                state_d = S_PRGA_CHK;
            end

            S_PRGA_CHK: begin
                if (pt < 8'h20 || pt > 8'h7E) begin
                    state_d = S_NEXT;
                end else if (k_q == len_q) begin
                    key_valid_d = 1'b1;
                    flagk_d     = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    k_d     = k_q + 8'd1;
                    state_d = S_PRGA_RI;
                end
            end

            S_NEXT: begin
                if (key_sum[24]) begin
                    key_valid_d = 1'b0;   // key space exhausted, key keeps last candidate
                    state_d     = S_IDLE;
                end else begin
                    key_d   = key_sum[23:0];
                    i_d     = 8'd0;
                    j_d     = 8'd0;
                    state_d = S_INIT;
                end
            end

            default: state_d = S_IDLE;
        endcase

        // A peer's find overrides everything, including our own success this cycle.
        if (kv && state_q != S_IDLE) begin
            state_d     = S_IDLE;
            key_valid_d = 1'b0;
            flagk_d     = 1'b0;
        end

        rdy_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q     <= S_IDLE;
            i_q         <= 8'd0;
            j_q         <= 8'd0;
            km_q        <= 2'd0;
            si_q        <= 8'd0;
            sj_q        <= 8'd0;
            len_q       <= 8'd0;
            k_q         <= 8'd0;
            key_q       <= 24'h000000;
            key_valid_q <= 1'b0;
            flagk_q     <= 1'b0;
            rdy_q       <= 1'b1;
            ct_addr_q   <= 8'd0;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            j_q         <= j_d;
            km_q        <= km_d;
            si_q        <= si_d;
            sj_q        <= sj_d;
            len_q       <= len_d;
            k_q         <= k_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
            flagk_q     <= flagk_d;
            rdy_q       <= rdy_d;
            ct_addr_q   <= ct_addr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (s_we0) s_q[s_wa0] <= s_wd0;
        if (s_we1) s_q[s_wa1] <= s_wd1;
        s_rd_q <= s_q[s_raddr];
    end

    assign rdy       = rdy_q;
    assign key       = key_q;
    assign key_valid = key_valid_q;
    assign flagk     = flagk_q;
    assign ct_addr   = ct_addr_q;

endmodule

// File: tb/tb_arc4_crack.sv
// Testbench for arc4_crack: drives searches against a ciphertext ROM model, predicts results
// with a software ARC4 search, and compares them when the block returns to idle.

module tb_arc4_crack;

`ifdef CRACK_STRIDE2_EN
    localparam logic [24:0] STEP = 25'd2;
`else
    localparam logic [24:0] STEP = 25'd1;
`endif

    logic        clk = 1'b0;
    logic        rst_n, en, rdy, key_valid, kv, flagk;
    logic [23:0] key_start, key;
    logic [7:0]  ct_addr, ct_rddata;

    logic [7:0]  ct_mem [256];

    int checks = 0;
    int failures = 0;
    int flagk_cnt = 0;
    int fk_base = 0;

    typedef struct {
        bit          found;
        logic [23:0] key;
        bit          chk_key;
        int          ncand;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    always @(posedge clk) ct_rddata <= ct_mem[ct_addr];

    // Counts cycles with flagk high (value held during the previous cycle).
    always @(posedge clk) if (flagk === 1'b1) flagk_cnt++;

    arc4_crack dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .rdy       (rdy),
        .key_start (key_start),
        .key       (key),
        .key_valid (key_valid),
        .ct_addr   (ct_addr),
        .ct_rddata (ct_rddata),
        .kv        (kv),
        .flagk     (flagk)
    );

    // n-th keystream byte (n >= 1) for a 3-byte ARC4 key.
    function automatic logic [7:0] model_pad(input logic [23:0] k, input int n);
        logic [7:0] s [256];
        logic [7:0] kb [3];
        logic [7:0] i, j, t, sw;
        kb[0] = k[23:16];
        kb[1] = k[15:8];
        kb[2] = k[7:0];
        for (int a = 0; a < 256; a++) s[a] = a[7:0];
        j = 8'd0;
        for (int a = 0; a < 256; a++) begin
            j    = j + s[a] + kb[a % 3];
            t    = s[a];
            s[a] = s[j];
            s[j] = t;
        end
        i  = 8'd0;
        j  = 8'd0;
        sw = 8'd0;
        for (int b = 1; b <= n; b++) begin
            i    = i + 8'd1;
            j    = j + s[i];
            t    = s[i];
            s[i] = s[j];
            s[j] = t;
            sw   = s[i] + s[j];
        end
        return s[sw];
    endfunction

    function automatic bit model_try(input logic [23:0] k);
        int len;
        len = int'(ct_mem[0]);
        for (int n = 1; n <= len; n++) begin
            logic [7:0] p;
            p = ct_mem[n] ^ model_pad(k, n);
            if (p < 8'h20 || p > 8'h7E) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic void model_search(input logic [23:0] start, output bit found,
                                         output logic [23:0] fkey, output int ncand);
        logic [24:0] k;
        k     = {1'b0, start};
        ncand = 0;
        found = 1'b0;
        fkey  = start;
        while (1) begin
            ncand++;
            if (model_try(k[23:0])) begin
                found = 1'b1;
                fkey  = k[23:0];
                return;
            end
            if (k + STEP > 25'h0FFFFFF) begin
                fkey = k[23:0];
                return;
            end
            k = k + STEP;
        end
    endfunction

    task automatic launch(input logic [23:0] ks, input bit abort);
        exp_t e;
        bit f;
        logic [23:0] fk;
        int nc;
        if (abort) begin
            e.found = 1'b0; e.key = 24'h0; e.chk_key = 1'b0; e.ncand = 1;
        end else begin
            model_search(ks, f, fk, nc);
            e.found = f; e.key = fk; e.chk_key = 1'b1; e.ncand = nc;
        end
        sb.push_back(e);
        @(negedge clk);
        checks++;
        if (rdy !== 1'b1) begin
            failures++; $display("FAIL launch_rdy got=%b want=1", rdy);
        end
        en = 1'b1;
        key_start = ks;
        fk_base = flagk_cnt;
        @(negedge clk);
        en = 1'b0;
        checks++;
        if (rdy !== 1'b0) begin
            failures++; $display("FAIL rdy_drop got=%b want=0", rdy);
        end
        checks++;
        if (key !== ks) begin
            failures++; $display("FAIL key_load got=%h want=%h", key, ks);
        end
        checks++;
        if (key_valid !== 1'b0) begin
            failures++; $display("FAIL key_valid_clear got=%b want=0", key_valid);
        end
    endtask

    task automatic finish_search();
        exp_t e;
        int budget, n;
        checks++;
        if (sb.size() == 0) begin
            failures++; $display("FAIL sb_empty got=0 want>0");
            return;
        end
        e = sb.pop_front();
        budget = e.ncand * (1032 + 6 * int'(ct_mem[0])) + 20;
        n = 0;
        while (rdy !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (rdy !== 1'b1) begin
            failures++; $display("FAIL done_timeout rdy=%b after %0d cycles want=1", rdy, n);
        end
        checks++;
        if (key_valid !== e.found) begin
            failures++; $display("FAIL key_valid got=%b want=%b", key_valid, e.found);
        end
        if (e.chk_key) begin
            checks++;
            if (key !== e.key) begin
                failures++; $display("FAIL result_key got=%h want=%h", key, e.key);
            end
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (flagk_cnt - fk_base != (e.found ? 1 : 0)) begin
            failures++;
            $display("FAIL flagk_pulses got=%0d want=%0d", flagk_cnt - fk_base, e.found ? 1 : 0);
        end
        checks++;
        if (flagk !== 1'b0) begin
            failures++; $display("FAIL flagk_idle got=%b want=0", flagk);
        end
    endtask

    task automatic check_reset_values(input string tag);
        checks++;
        if (rdy !== 1'b1) begin failures++; $display("FAIL %s_rdy got=%b want=1", tag, rdy); end
        checks++;
        if (key_valid !== 1'b0) begin failures++; $display("FAIL %s_key_valid got=%b want=0", tag, key_valid); end
        checks++;
        if (key !== 24'h000000) begin failures++; $display("FAIL %s_key got=%h want=000000", tag, key); end
        checks++;
        if (flagk !== 1'b0) begin failures++; $display("FAIL %s_flagk got=%b want=0", tag, flagk); end
        checks++;
        if (ct_addr !== 8'h00) begin failures++; $display("FAIL %s_ct_addr got=%h want=00", tag, ct_addr); end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b0;
    endtask

    task automatic test_empty_msg();
        ct_mem[0] = 8'd0;
        launch(24'h000005, 1'b0);
        finish_search();
    endtask

    task automatic test_hi();
        ct_mem[0] = 8'd2;
        ct_mem[1] = 8'h68 ^ model_pad(24'h000018, 1);
        ct_mem[2] = 8'h69 ^ model_pad(24'h000018, 2);
        launch(24'h000010, 1'b0);
        finish_search();
    endtask

    task automatic test_exhaust();
        ct_mem[0] = 8'd2;
        ct_mem[1] = 8'h02;
        ct_mem[2] = 8'h02;
        launch(24'hFFFFF0, 1'b0);
        finish_search();
    endtask

    task automatic test_kv();
        // Abort during KSA.
        launch(24'hFFFFF0, 1'b1);
        repeat (300) @(negedge clk);
        kv = 1'b1;
        @(negedge clk);
        kv = 1'b0;
        checks++;
        if (rdy !== 1'b1) begin failures++; $display("FAIL kv_ksa_rdy got=%b want=1", rdy); end
        checks++;
        if (key_valid !== 1'b0) begin failures++; $display("FAIL kv_ksa_key_valid got=%b want=0", key_valid); end
        finish_search();
        // Abort early in PRGA.
        ct_mem[0] = 8'd2;
        ct_mem[1] = 8'h68 ^ model_pad(24'h000018, 1);
        ct_mem[2] = 8'h69 ^ model_pad(24'h000018, 2);
        launch(24'h000010, 1'b1);
        repeat (1027) @(negedge clk);
        kv = 1'b1;
        @(negedge clk);
        kv = 1'b0;
        checks++;
        if (rdy !== 1'b1) begin failures++; $display("FAIL kv_prga_rdy got=%b want=1", rdy); end
        finish_search();
    endtask

    task automatic test_en_ignored();
        ct_mem[0] = 8'd0;
        launch(24'h000005, 1'b0);
        repeat (10) @(negedge clk);
        en = 1'b1;
        key_start = 24'h123456;
        @(negedge clk);
        en = 1'b0;
        checks++;
        if (rdy !== 1'b0) begin failures++; $display("FAIL busy_en_rdy got=%b want=0", rdy); end
        checks++;
        if (key !== 24'h000005) begin failures++; $display("FAIL busy_en_key got=%h want=000005", key); end
        finish_search();
    endtask

    task automatic test_back_to_back();
        ct_mem[0] = 8'd0;
        launch(24'h000007, 1'b0);
        finish_search();
        // kv while idle must not disturb the held result.
        kv = 1'b1;
        @(negedge clk);
        kv = 1'b0;
        checks++;
        if (key_valid !== 1'b1 || rdy !== 1'b1) begin
            failures++; $display("FAIL idle_kv got=%b%b want=11", key_valid, rdy);
        end
        launch(24'h000008, 1'b0);
        finish_search();
    endtask

    task automatic test_reset_mid();
        ct_mem[0] = 8'd2;
        ct_mem[1] = 8'h02;
        ct_mem[2] = 8'h02;
        launch(24'hFFFFF0, 1'b1);
        repeat (500) @(negedge clk);
        rst_n = 1'b1;
        en = 1'b1;
        kv = 1'b1;
        key_start = 24'hABCDEF;
        @(negedge clk);
        rst_n = 1'b0;
        en = 1'b0;
        kv = 1'b0;
        check_reset_values("midreset");
        finish_search();
    endtask

    initial begin
        rst_n = 1'b1;
        en = 1'b0;
        kv = 1'b0;
        key_start = 24'h0;
        for (int a = 0; a < 256; a++) ct_mem[a] = 8'h00;
        test_reset();
        test_empty_msg();
        test_hi();
        test_exhaust();
        test_kv();
        test_en_ignored();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/arc4_crack.md
ARC4_CRACK -- requirements
Module: arc4_crack

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all logic updates on the rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: synchronous reset, active-high (asserted = 1), sampled on the clk rising edge.
REQ-003 SHALL have port en, input, 1 bit: start request; accepted only while rdy=1.
REQ-004 SHALL have port rdy, output, 1 bit: 1 = idle and ready to accept en.
REQ-005 SHALL have port key_start, input, 24 bits: first candidate key; sampled when en is accepted.
REQ-006 SHALL have port key, output, 24 bits: current candidate key register; holds the found key when the search completes with success.
REQ-007 SHALL have port key_valid, output, 1 bit: 1 = the last search found a key; meaningful only while rdy=1.
REQ-008 SHALL have port ct_addr, output, 8 bits: ciphertext memory address.
REQ-009 SHALL have port ct_rddata, input, 8 bits: ciphertext data; valid 1 cycle after ct_addr (synchronous ROM).
REQ-010 SHALL have port kv, input, 1 bit: external abort (a peer cracker has found the key).
REQ-011 SHALL have port flagk, output, 1 bit: single-cycle pulse when this block finds a key.

Function
REQ-012 Ciphertext format SHALL be ct[0] = message length L (0..255), followed by ct[1..L] = cipher bytes.
REQ-013 The key schedule SHALL be ARC4 with a 3-byte key; key byte i mod 3 is taken from {key[23:16], key[15:8], key[7:0]}.
REQ-014 SHALL hold a 256x8 internal S array with a 1-cycle read latency.
REQ-015 State machine: IDLE -> INIT -> KSA -> PRGA -> (DONE | NEXT) -> ...
  - IDLE: rdy=1; on en, load key=key_start, clear key_valid, go to INIT.
  - INIT: write S[i]=i for i=0..255.
  - KSA: j = j + S[i] + keybyte (mod 256), then swap S[i] and S[j].
  - PRGA: read L, then for k = 1..L: i++, j += S[i], swap, pad = S[S[i]+S[j]], pt = ct[k] ^ pad.
REQ-016 A plaintext byte SHALL be accepted only if it is in 0x20..0x7E; on the first rejected byte, abort immediately and go to NEXT.
REQ-017 If all L bytes are accepted (including L=0), the search SHALL succeed: key_valid=1, flagk=1 for exactly one cycle, then go to IDLE with rdy=1 and key holding the found value.
REQ-018 NEXT SHALL add KEY_STEP to key and restart at INIT. If the addition would exceed 24'hFFFFFF, the search SHALL fail: go to IDLE with key_valid=0 and key unchanged.
REQ-019 kv=1 in any non-IDLE state SHALL force IDLE on the next cycle with key_valid=0 and flagk=0. kv has priority over a success occurring in the same cycle.
REQ-020 en SHALL be ignored while rdy=0. rdy SHALL drop the cycle after en is accepted.
REQ-021 A single candidate SHALL complete within 256 + 3*256 + 6*L + 8 cycles.

Reset
REQ-022 rst_n=1 SHALL force, on the next edge: IDLE, rdy=1, key_valid=0, flagk=0, key=24'h000000, ct_addr=0, i=j=0.
REQ-023 Reset mid-search SHALL abandon the search with no flagk pulse. Reset SHALL take priority over en and kv.

Configuration
REQ-024 Macro CRACK_STRIDE2_EN: when defined, KEY_STEP=2, so two instances started at key_start 0 and 1 partition the keyspace. When undefined, KEY_STEP=1.

Verification
REQ-025 Reset with rst_n=1 for 1 cycle -> rdy=1, key_valid=0, key=0, flagk=0.
REQ-026 ct[0]=0, key_start=24'h000005, 1-cycle en -> rdy=1, key_valid=1, key=24'h000005, exactly one flagk pulse.
REQ-027 ct = "hi" (L=2) encrypted with key 24'h000018 by the software model, key_start=24'h000010 -> key_valid=1, key=24'h000018 (both stride settings).
REQ-028 ct[0]=2, ct[1..2]=8'h02 with no printable key in range (confirmed by the model), key_start=24'hFFFFF0 -> rdy=1, key_valid=0 after 16 (stride 1) or 8 (stride 2) candidates.
REQ-029 Search running, pulse kv=1 -> rdy=1 on the next cycle, key_valid=0, no flagk pulse.
REQ-030 Search running: en pulses are ignored; rst_n=1 asserted mid-search -> IDLE next cycle with the REQ-022 values.
